// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one UartTx from two byte sources, each buffered
// in its own FIFO, and follows the transmitter through its tx_busy handshake.
module uart_tx_arbiter #(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ch0_valid,
  input  logic [7:0] ch0_data,
  output logic       ch0_ready,
  input  logic       ch1_valid,
  input  logic [7:0] ch1_data,
  output logic       ch1_ready,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] sdata,
  output logic       active,
  output logic       timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t state, next_state;

  logic [7:0]    mem [2][DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [AW:0]   count [2];
  logic [1:0]    in_valid;
  logic [7:0]    in_data [2];
  logic [1:0]    ready;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    nonempty;

  logic          sel;
  logic          last_grant;
  logic [7:0]    sdata_q;
  logic [7:0]    head;
  logic [CW-1:0] wait_cnt;

  assign in_valid   = {ch1_valid, ch0_valid};
  assign in_data[0] = ch0_data;
  assign in_data[1] = ch1_data;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      ready[c]    = (count[c] != FULL_COUNT);
      nonempty[c] = (count[c] != '0);
      push[c]     = in_valid[c] && ready[c];
    end
  end

  assign ch0_ready = ready[0];
  assign ch1_ready = ready[1];

  always_ff @(posedge clock) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= in_data[c];
      end
    end
  end

  // Pointers wrap naturally at DEPTH because their width is exactly log2(DEPTH).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          wr_ptr[c] <= wr_ptr[c] + AW'(1);
        end
        if (pop[c]) begin
          rd_ptr[c] <= rd_ptr[c] + AW'(1);
        end
        unique case ({push[c], pop[c]})
          2'b10:   count[c] <= count[c] + (AW + 1)'(1);
          2'b01:   count[c] <= count[c] - (AW + 1)'(1);
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  assign head = mem[sel][rd_ptr[sel]];

  always_comb begin
    next_state  = state;
    pop         = 2'b00;
    sel         = 1'b0;
    tx_start    = 1'b0;
    timeout_err = 1'b0;
    unique case (state)
      IDLE: begin
        sel = (nonempty[0] && nonempty[1]) ? ~last_grant : nonempty[1];
        if (!reset && !tx_busy && (nonempty != 2'b00)) begin
          tx_start   = 1'b1;
          pop        = sel ? 2'b10 : 2'b01;
          next_state = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          next_state = WAIT_LO;
        end else if (wait_cnt == TIMEOUT_VAL) begin
          timeout_err = !reset;
          next_state  = IDLE;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // sdata shows the FIFO head during the start pulse, then the registered copy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      sdata_q    <= 8'h00;
      wait_cnt   <= '0;
    end else begin
      state <= next_state;
      if (tx_start) begin
        sdata_q    <= head;
        last_grant <= sel;
        wait_cnt   <= CW'(1);
      end else if (state == WAIT_HI) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  assign sdata  = tx_start ? head : sdata_q;
  assign active = (state != IDLE) || nonempty[0] || nonempty[1];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table for the handshake and
// arbitration order, then hand sequences for backpressure, wrap and reset.
module tb_uart_tx_arbiter;

  localparam int BUDGET     = 400;
  localparam int MOCK_FRAME = 4;

  logic       clock;
  logic       reset;
  logic       ch0_valid;
  logic [7:0] ch0_data;
  logic       ch0_ready;
  logic       ch1_valid;
  logic [7:0] ch1_data;
  logic       ch1_ready;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] sdata;
  logic       active;
  logic       timeout_err;

  logic       tb_busy;
  logic       mock_en;
  int         mock_cnt;

  int         checks;
  int         failures;

  logic [7:0] rx_mem [0:255];
  int         rx_n;
  logic       prev_start;
  int         viol;

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       busy;
    logic       e_start;
    logic [7:0] e_sdata;
    logic       chk_sdata;
    logic       e_active;
    logic       e_to;
  } vec_t;

  vec_t vecs[$];

  uart_tx_arbiter #(
    .DEPTH(16),
    .ACK_TIMEOUT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ch0_valid(ch0_valid),
    .ch0_data(ch0_data),
    .ch0_ready(ch0_ready),
    .ch1_valid(ch1_valid),
    .ch1_data(ch1_data),
    .ch1_ready(ch1_ready),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .sdata(sdata),
    .active(active),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in transmitter: busy for MOCK_FRAME cycles after each start pulse.
  always @(posedge clock) begin
    if (!mock_en || reset) begin
      mock_cnt <= 0;
    end else if (mock_cnt != 0) begin
      mock_cnt <= mock_cnt - 1;
    end else if (tx_start) begin
      mock_cnt <= MOCK_FRAME;
    end
  end

  assign tx_busy = mock_en ? (mock_cnt != 0) : tb_busy;

  initial begin
    rx_n       = 0;
    viol       = 0;
    prev_start = 1'b0;
  end

  always @(negedge clock) begin
    if (!reset && tx_start) begin
      rx_mem[rx_n[7:0]] <= sdata;
      rx_n <= rx_n + 1;
    end
    if (tx_start && prev_start) begin
      viol <= viol + 1;
    end
    prev_start <= tx_start;
  end

  function automatic void addVec(input logic rst, input logic v0, input logic [7:0] d0,
                                 input logic v1, input logic [7:0] d1, input logic busy,
                                 input logic e_start, input logic [7:0] e_sdata,
                                 input logic chk_sdata, input logic e_active,
                                 input logic e_to);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.busy = busy;
    v.e_start = e_start; v.e_sdata = e_sdata; v.chk_sdata = chk_sdata;
    v.e_active = e_active; v.e_to = e_to;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset     = v.rst;
    ch0_valid = v.v0;
    ch0_data  = v.d0;
    ch1_valid = v.v1;
    ch1_data  = v.d1;
    tb_busy   = v.busy;
  endtask

  task automatic pushByte(input int ch, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    if (ch == 0) begin
      ch0_valid = 1'b1; ch0_data = d;
    end else begin
      ch1_valid = 1'b1; ch1_data = d;
    end
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clock);
      if ((ch == 0) ? ch0_ready : ch1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL push_ch%0d_timeout actual=not_ready expected=ready", ch);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic waitIdle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clock);
      if (!active && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(name, {31'd0, ok}, 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int rx_start;
    int rx_snap;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    ch0_valid = 1'b0; ch0_data = 8'h00;
    ch1_valid = 1'b0; ch1_data = 8'h00;
    tb_busy   = 1'b0;
    mock_en   = 1'b0;
    @(posedge clock);

    //     rst v0 d0     v1 d1     busy st sdata  chk act to
    addVec(1, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 1,  0,  0);
    // single byte: push at t, start at t+1, active drops after busy drops
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 1,  0,  0);
    addVec(0, 1, 8'h55, 0, 8'h00, 0,   0, 8'h00, 1,  0,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h55, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h55, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h55, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h55, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h55, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h55, 1,  0,  0);
    // contention: expected order 01, A1, 02, A2
    addVec(1, 0, 8'h00, 0, 8'h00, 0,   0, 8'h00, 0,  0,  0);
    addVec(0, 1, 8'h01, 1, 8'hA1, 0,   0, 8'h00, 1,  0,  0);
    addVec(0, 1, 8'h02, 1, 8'hA2, 0,   1, 8'h01, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h01, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h01, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h01, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'hA1, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'hA1, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'hA1, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h02, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h02, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h02, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'hA2, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'hA2, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'hA2, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'hA2, 1,  0,  0);
    // timeout: start on 7E, error 8 cycles later, then 3C goes out
    addVec(0, 1, 8'h7E, 0, 8'h00, 0,   0, 8'hA2, 1,  0,  0);
    addVec(0, 1, 8'h3C, 0, 8'h00, 0,   1, 8'h7E, 1,  1,  0);
    for (int i = 0; i < 7; i++)
      addVec(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h7E, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h7E, 1,  1,  1);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   1, 8'h3C, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h3C, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h3C, 1,  1,  0);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,   0, 8'h3C, 1,  0,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clock);
      checkOutput($sformatf("v%0d_tx_start", i), {31'd0, tx_start}, {31'd0, vecs[i].e_start});
      if (vecs[i].chk_sdata)
        checkOutput($sformatf("v%0d_sdata", i), {24'd0, sdata}, {24'd0, vecs[i].e_sdata});
      checkOutput($sformatf("v%0d_ch0_ready", i), {31'd0, ch0_ready}, 32'd1);
      checkOutput($sformatf("v%0d_ch1_ready", i), {31'd0, ch1_ready}, 32'd1);
      checkOutput($sformatf("v%0d_active", i), {31'd0, active}, {31'd0, vecs[i].e_active});
      checkOutput($sformatf("v%0d_timeout_err", i), {31'd0, timeout_err}, {31'd0, vecs[i].e_to});
    end
    @(posedge clock);
    #1;
    applyStimulus('{default: '0});

    // Backpressure: transmitter held busy, ch1 fills to 16, the 17th waits
    tb_busy  = 1'b1;
    rx_start = rx_n;
    for (int i = 0; i < 16; i++) pushByte(1, 8'(i));
    ch1_valid = 1'b1;
    ch1_data  = 8'h10;
    @(negedge clock);
    checkOutput("bp_ready_low_when_full", {31'd0, ch1_ready}, 32'd0);
    checkOutput("bp_active_while_queued", {31'd0, active}, 32'd1);
    @(posedge clock);
    #1;
    mock_en = 1'b1;
    pushByte(1, 8'h10);
    ch1_valid = 1'b0;
    waitIdle("bp_drain");
    checkOutput("bp_rx_count", rx_n - rx_start, 32'd17);
    for (int i = 0; i < 17; i++)
      checkOutput($sformatf("bp_byte%0d", i), {24'd0, rx_mem[(rx_start + i) % 256]}, i);

    // Wrap-around: 40 bytes streamed on ch0 with valid held high
    rx_start = rx_n;
    for (int i = 0; i < 40; i++) pushByte(0, 8'(i));
    ch0_valid = 1'b0;
    waitIdle("wrap_drain");
    checkOutput("wrap_rx_count", rx_n - rx_start, 32'd40);
    for (int i = 0; i < 40; i++)
      checkOutput($sformatf("wrap_byte%0d", i), {24'd0, rx_mem[(rx_start + i) % 256]}, i);

    // Reset in WAIT_LO with three bytes queued per channel
    mock_en = 1'b0;
    tb_busy = 1'b0;
    ch0_valid = 1'b1; ch0_data = 8'hAA;
    @(posedge clock); #1;
    ch0_data = 8'hB0; ch1_valid = 1'b1; ch1_data = 8'hC0;
    @(negedge clock);
    checkOutput("rst_pre_start", {31'd0, tx_start}, 32'd1);
    checkOutput("rst_pre_sdata", {24'd0, sdata}, 32'hAA);
    @(posedge clock); #1;
    ch0_data = 8'hB1; ch1_data = 8'hC1; tb_busy = 1'b1;
    @(posedge clock); #1;
    ch0_data = 8'hB2; ch1_data = 8'hC2;
    @(posedge clock); #1;
    ch0_valid = 1'b0; ch1_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    checkOutput("rst_cycle_start_low", {31'd0, tx_start}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; tb_busy = 1'b0; rx_snap = rx_n;
    @(negedge clock);
    checkOutput("rst_ch0_ready", {31'd0, ch0_ready}, 32'd1);
    checkOutput("rst_ch1_ready", {31'd0, ch1_ready}, 32'd1);
    checkOutput("rst_active", {31'd0, active}, 32'd0);
    checkOutput("rst_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("rst_last_rx", {24'd0, rx_mem[(rx_snap + 255) % 256]}, 32'hAA);

    // Reset while IDLE with a queued byte must not issue a start
    @(posedge clock); #1;
    ch0_valid = 1'b1; ch0_data = 8'h5A; tb_busy = 1'b1;
    @(posedge clock); #1;
    ch0_valid = 1'b0; tb_busy = 1'b0; reset = 1'b1;
    @(negedge clock);
    checkOutput("idle_rst_no_start", {31'd0, tx_start}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("idle_rst_active", {31'd0, active}, 32'd0);
    repeat (20) @(posedge clock);
    #1;
    checkOutput("rst_no_queued_tx", rx_n, rx_snap);
    checkOutput("no_back_to_back_start", viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UartTx transmitter between two byte sources: ch0 (DMA controller) and ch1 (memory controller hub).
Each source pushes bytes into its own FIFO with a valid/ready handshake, so no byte is lost when both sources want to send.
A round-robin arbiter drains the FIFOs one byte at a time and tracks the transmitter through its tx_busy handshake.
This block replaces the ad-hoc OR/priority mux on tx_start/sdata.

Parameters:
DEPTH, 16, entries per channel FIFO; power of two, minimum 2
ACK_TIMEOUT, 8, cycles to wait for tx_busy to rise after a tx_start pulse before abandoning the byte

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
ch0_valid  input  1  ch0 offers a byte this cycle
ch0_data  input  8  ch0 byte
ch0_ready  output  1  ch0 FIFO not full; a byte is accepted when valid && ready
ch1_valid  input  1  ch1 offers a byte this cycle
ch1_data  input  8  ch1 byte
ch1_ready  output  1  ch1 FIFO not full
tx_busy  input  1  from UartTx
tx_start  output  1  one-cycle start pulse to UartTx
sdata  output  8  byte to UartTx; valid while tx_start=1, then held until the next start
active  output  1  high when a byte is in flight or either FIFO is non-empty
timeout_err  output  1  one-cycle pulse when ACK_TIMEOUT expires

Behaviour:
- Reset: only the clock and reset ports follow the already-decided rule — one clock; reset is synchronous and active-high. On reset:
  - both FIFOs empty (pointers and counts = 0); state=IDLE; last_grant=1, so ch0 wins the first tie.
  - tx_start=0, sdata=0x00, timeout_err=0, active=0.
  - chN_ready=1 from the first cycle after reset.
- Asserting reset mid-transfer flushes both FIFOs and returns to IDLE. No tx_start is issued in the reset cycle.
- FIFOs:
  - chN_ready = (countN != DEPTH), combinational.
  - Push when chN_valid && chN_ready; a push while full is impossible because ready is low.
  - A push and a pop on the same FIFO in the same cycle both take effect; the count is unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
  - A byte pushed in cycle t is eligible for arbitration from cycle t+1; there is no write-through.
- State machine: IDLE -> WAIT_HI -> WAIT_LO -> IDLE.
  - IDLE:
    - If tx_busy==0 and at least one FIFO is non-empty, select a channel:
      - only one non-empty: take it.
      - both non-empty: take the channel != last_grant.
    - On selection, in the same cycle: pop the selected head, register it into sdata, pulse tx_start=1, set last_grant, go to WAIT_HI.
    - If tx_busy==1 in IDLE (transmitter still busy from another cause), wait and issue nothing.
  - WAIT_HI:
    - tx_start=0; count cycles from 1.
    - If tx_busy==1, go to WAIT_LO.
    - If the counter reaches ACK_TIMEOUT with tx_busy still 0: pulse timeout_err for one cycle, go to IDLE. The byte is dropped, not retried.
  - WAIT_LO: when tx_busy==0, go to IDLE. The next tx_start can occur in the following cycle at the earliest.
- Latency: with both FIFOs empty and the transmitter idle, a byte pushed in cycle t produces tx_start in cycle t+1.
- Throughput: at most one byte per UartTx frame. Arbitration alternates strictly while both channels are backlogged.
- tx_start is never high on two consecutive cycles, and never high while the state is WAIT_HI or WAIT_LO.
- active = (state != IDLE) || (count0 != 0) || (count1 != 0).

Test Plan:
- Single byte: after reset, ch0 pushes 0x55 at cycle t -> tx_start=1 and sdata=0x55 at t+1. UartTx (CLK_PER_HALF_BIT=10) serialises it, and txd shows start bit, 0x55 LSB first, stop bit. active falls after tx_busy falls.
- Contention: ch0 pushes 0x01,0x02 and ch1 pushes 0xA1,0xA2 in the same cycles -> transmit order 0x01,0xA1,0x02,0xA2, one tx_start per frame.
- Backpressure: ch1 pushes 17 bytes 0x00..0x10 back-to-back with UartTx busy -> ch1_ready drops after 16 accepted bytes. 0x10 is accepted only once a slot frees. All 17 bytes emerge in order.
- FIFO wrap-around: ch0 streams 40 bytes 0x00..0x27 with valid always high -> all 40 are received in order. Simultaneous push/pop cycles keep count0 correct across pointer wrap.
- Timeout: tie tx_busy=0 and push 0x7E on ch0 -> tx_start pulses once. timeout_err pulses exactly ACK_TIMEOUT=8 cycles later, the state returns to IDLE, and the next queued byte is issued.
- Reset mid-operation: assert reset for one cycle while in WAIT_LO with 3 bytes queued on each channel -> both FIFOs empty, chN_ready=1, tx_start=0, active=0. No queued byte is ever transmitted.
